// File: rtl/i2c_target_regfile_if.sv
// i2c_target_regfile_if: I2C pad signals and fabric register-port signals of the I2C target
interface i2c_target_regfile_if;
  logic       I2C_SCL_I;
  logic       I2C_SDA_I;
  logic       I2C_SDA_O;
  logic       I2C_SDA_T;
  logic [7:0] REG_RADDR;
  logic [7:0] REG_RDATA;
  logic       REG_WE;
  logic [7:0] REG_WADDR;
  logic [7:0] REG_WDATA;
  logic       BUSY;
  modport slave (
    input  I2C_SCL_I, I2C_SDA_I, REG_RADDR,
    output I2C_SDA_O, I2C_SDA_T, REG_RDATA, REG_WE, REG_WADDR, REG_WDATA, BUSY
  );
  modport master (
    output I2C_SCL_I, I2C_SDA_I, REG_RADDR,
    input  I2C_SDA_O, I2C_SDA_T, REG_RDATA, REG_WE, REG_WADDR, REG_WDATA, BUSY
  );
endinterface

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target with a 256x8 register file, fabric read port and write strobe
module i2c_target_regfile #(
  parameter logic [6:0] DEVICE_ADDR = 7'h39,
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input logic ACLK,
  input logic nRST,
  i2c_target_regfile_if.slave bus
);
  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] ADDR      = 4'd1;
  localparam logic [3:0] ADDR_ACK  = 4'd2;
  localparam logic [3:0] SUB       = 4'd3;
  localparam logic [3:0] SUB_ACK   = 4'd4;
  localparam logic [3:0] WDATA     = 4'd5;
  localparam logic [3:0] WDATA_ACK = 4'd6;
  localparam logic [3:0] RDATA     = 4'd7;
  localparam logic [3:0] RACK      = 4'd8;
  localparam logic [3:0] WAIT      = 4'd9;
  // bits [1:0] are the synchronizer, bit [2] is the history stage for edge detection
  logic [2:0] scl_q, sda_q;
  logic [3:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] ptr_q, ptr_d;
  logic       sda_t_q, sda_t_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic       we_q, we_d;
  logic [7:0] waddr_q, waddr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q;
  logic [7:0] mem_q [256];
  logic       scl_rise, scl_fall, start, stop, match;
  logic [7:0] byte_w, rd_w;
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  assign byte_w   = {sh_q[6:0], sda_q[1]};
  assign match    = sh_q[6:0] == DEVICE_ADDR;
  assign rd_w     = mem_q[ptr_q];
  // protocol FSM: bits shift in on SCL rise, SDA drive changes only on SCL fall
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    sda_t_d = sda_t_q;
    rw_d    = rw_q;
    busy_d  = busy_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (start) begin
      state_d = ADDR;
      cnt_d   = 4'd0;
    end else if (stop) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        ADDR, SUB, WDATA: begin
          sh_d  = byte_w;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            if (state_q == ADDR) begin
              state_d = match ? ADDR_ACK : WAIT;
              rw_d    = sda_q[1];
              busy_d  = busy_q | match;
            end else if (state_q == SUB) begin
              ptr_d   = byte_w;
              state_d = SUB_ACK;
            end else begin
              we_d    = 1'b1;
              waddr_d = ptr_q;
              wdata_d = byte_w;
              ptr_d   = ptr_q + 8'd1;
              state_d = WDATA_ACK;
            end
          end
        end
        ADDR_ACK: begin
          cnt_d   = 4'd0;
          state_d = rw_q ? RDATA : SUB;
        end
        SUB_ACK, WDATA_ACK: begin
          cnt_d   = 4'd0;
          state_d = WDATA;
        end
        RDATA: cnt_d = cnt_q + 4'd1;
        RACK: begin
          cnt_d   = 4'd0;
          state_d = sda_q[1] ? WAIT : RDATA;
          busy_d  = busy_q & ~sda_q[1];
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        ADDR, SUB, WDATA: sda_t_d = 1'b1;
        ADDR_ACK, SUB_ACK, WDATA_ACK: sda_t_d = 1'b0;
        RDATA: begin
          if (cnt_q == 4'd0) begin
            sda_t_d = rd_w[7];
            sh_d    = {rd_w[6:0], 1'b0};
            ptr_d   = ptr_q + 8'd1;
          end else if (cnt_q == 4'd8) begin
            sda_t_d = 1'b1;
            state_d = RACK;
          end else begin
            sda_t_d = sh_q[7];
            sh_d    = {sh_q[6:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end
  // pin synchronizers and FSM state; reset releases SDA immediately
  always_ff @(posedge ACLK or negedge nRST) begin
    if (!nRST) begin
      scl_q   <= 3'b111;
      sda_q   <= 3'b111;
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sh_q    <= 8'h00;
      ptr_q   <= 8'h00;
      sda_t_q <= 1'b1;
      rw_q    <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= 8'h00;
      wdata_q <= 8'h00;
    end else begin
      scl_q   <= {scl_q[1:0], bus.I2C_SCL_I};
      sda_q   <= {sda_q[1:0], bus.I2C_SDA_I};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      sda_t_q <= sda_t_d;
      rw_q    <= rw_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
  // register file: written by the I2C master, read by fabric with old-value-on-collision
  always_ff @(posedge ACLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < 256; i++) mem_q[i] <= RESET_VALUE;
      rdata_q <= RESET_VALUE;
    end else begin
      if (we_d) mem_q[ptr_q] <= byte_w;
      rdata_q <= mem_q[bus.REG_RADDR];
    end
  end
  assign bus.I2C_SDA_O = 1'b0;
  assign bus.I2C_SDA_T = sda_t_q;
  assign bus.REG_RDATA = rdata_q;
  assign bus.REG_WE    = we_q;
  assign bus.REG_WADDR = waddr_q;
  assign bus.REG_WDATA = wdata_q;
  assign bus.BUSY      = busy_q;
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb_i2c_target_regfile: bit-level I2C master driving the target, checked against an array model
`timescale 1ns/1ps
module tb_i2c_target_regfile;
  localparam int T = 12;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int sda_low_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] mem_m [256];
  logic [7:0] ptr_m;
  logic [15:0] we_log [$];
  logic [7:0] wq [$];
  i2c_target_regfile_if bus();
  i2c_target_regfile dut (.ACLK(clk), .nRST(rst_n), .bus(bus));
  assign bus.I2C_SCL_I = scl_m;
  assign bus.I2C_SDA_I = sda_m & (bus.I2C_SDA_T | bus.I2C_SDA_O);
  always #5 clk = ~clk;
  // passive monitor: write strobes, SDA drive activity, BUSY activity
  always @(negedge clk) begin
    if (bus.REG_WE) we_log.push_back({bus.REG_WADDR, bus.REG_WDATA});
    if (!bus.I2C_SDA_T) sda_low_cnt++;
    if (bus.BUSY) busy_cnt++;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset;
    foreach (mem_m[i]) mem_m[i] = 8'h00;
    ptr_m = 8'h00;
  endtask
  task automatic i2c_start;
    sda_m = 1'b1;
    cyc(T);
    scl_m = 1'b1;
    cyc(T);
    sda_m = 1'b0;
    cyc(T);
    scl_m = 1'b0;
  endtask
  task automatic i2c_stop;
    cyc(2);
    sda_m = 1'b0;
    cyc(T);
    scl_m = 1'b1;
    cyc(T);
    sda_m = 1'b1;
    cyc(T);
  endtask
  task automatic clock_bit(input logic b, output logic s);
    cyc(2);
    sda_m = b;
    cyc(T);
    scl_m = 1'b1;
    cyc(T / 2);
    s = bus.I2C_SDA_I;
    cyc(T - T / 2);
    scl_m = 1'b0;
  endtask
  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask
  task automatic rd_byte(input logic ack_in, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(~ack_in, s);
  endtask
  task automatic fab(input logic [7:0] a, input string tag);
    bus.REG_RADDR = a;
    cyc(2);
    check(tag, 16'(bus.REG_RDATA), 16'(mem_m[a]));
  endtask
  task automatic do_write(input logic [7:0] sub, input string tag);
    int base;
    logic a;
    base = we_log.size();
    i2c_start;
    wr_byte(8'h72, a);
    check({tag, "/addr_ack"}, 16'(a), 16'd1);
    check({tag, "/busy"}, 16'(bus.BUSY), 16'd1);
    wr_byte(sub, a);
    check({tag, "/sub_ack"}, 16'(a), 16'd1);
    ptr_m = sub;
    foreach (wq[i]) begin
      wr_byte(wq[i], a);
      check({tag, "/data_ack"}, 16'(a), 16'd1);
    end
    i2c_stop;
    cyc(4);
    check({tag, "/we_count"}, 16'(we_log.size() - base), 16'(wq.size()));
    foreach (wq[i]) begin
      if (base + i < we_log.size()) check({tag, "/we"}, we_log[base + i], {ptr_m, wq[i]});
      mem_m[ptr_m] = wq[i];
      ptr_m++;
    end
    check({tag, "/busy_end"}, 16'(bus.BUSY), 16'd0);
  endtask
  task automatic do_read(input logic use_sub, input logic [7:0] sub, input int n, input string tag);
    logic a;
    logic [7:0] b;
    int c0;
    i2c_start;
    if (use_sub) begin
      wr_byte(8'h72, a);
      check({tag, "/waddr_ack"}, 16'(a), 16'd1);
      wr_byte(sub, a);
      check({tag, "/sub_ack"}, 16'(a), 16'd1);
      ptr_m = sub;
      i2c_start;
    end
    wr_byte(8'h73, a);
    check({tag, "/raddr_ack"}, 16'(a), 16'd1);
    for (int i = 0; i < n; i++) begin
      rd_byte(i != n - 1, b);
      check({tag, "/rdata"}, 16'(b), 16'(mem_m[ptr_m]));
      ptr_m++;
    end
    check({tag, "/busy_after_nack"}, 16'(bus.BUSY), 16'd0);
    c0 = sda_low_cnt;
    i2c_stop;
    check({tag, "/released_to_stop"}, 16'(sda_low_cnt - c0), 16'd0);
  endtask
  initial begin
    logic a, s;
    int base, c0, b0, op;
    bus.REG_RADDR = 8'h00;
    cyc(3);
    check("rst/sda_t", 16'(bus.I2C_SDA_T), 16'd1);
    check("rst/sda_o", 16'(bus.I2C_SDA_O), 16'd0);
    check("rst/we", 16'(bus.REG_WE), 16'd0);
    check("rst/waddr", 16'(bus.REG_WADDR), 16'd0);
    check("rst/wdata", 16'(bus.REG_WDATA), 16'd0);
    check("rst/busy", 16'(bus.BUSY), 16'd0);
    check("rst/rdata", 16'(bus.REG_RDATA), 16'd0);
    rst_n = 1'b1;
    model_reset();
    cyc(5);
    wq = {8'h10};
    do_write(8'h41, "wr1");
    fab(8'h41, "wr1/fab41");
    wq = {8'hA1, 8'hA2, 8'hA3};
    do_write(8'hFE, "burst");
    fab(8'hFE, "burst/fabFE");
    fab(8'hFF, "burst/fabFF");
    fab(8'h00, "burst/fab00");
    do_read(1'b1, 8'h41, 2, "rd2");
    base = we_log.size();
    c0 = sda_low_cnt;
    b0 = busy_cnt;
    i2c_start;
    wr_byte(8'h74, a);
    check("mismatch/ack", 16'(a), 16'd0);
    wr_byte(8'h41, a);
    wr_byte(8'h55, a);
    i2c_stop;
    check("mismatch/sda_t", 16'(sda_low_cnt - c0), 16'd0);
    check("mismatch/we", 16'(we_log.size() - base), 16'd0);
    check("mismatch/busy", 16'(busy_cnt - b0), 16'd0);
    base = we_log.size();
    i2c_start;
    wr_byte(8'h72, a);
    wr_byte(8'h10, a);
    ptr_m = 8'h10;
    for (int i = 0; i < 4; i++) clock_bit(i[0], s);
    i2c_stop;
    cyc(4);
    check("abort/we", 16'(we_log.size() - base), 16'd0);
    check("abort/busy", 16'(bus.BUSY), 16'd0);
    wq = {8'h5A};
    do_write(8'h20, "after_abort");
    fab(8'h20, "after_abort/fab20");
    do_read(1'b0, 8'h00, 1, "cont");
    i2c_start;
    for (int i = 7; i >= 0; i--) clock_bit(i == 6 || i == 5 || i == 4 || i == 1, s);
    cyc(2);
    sda_m = 1'b1;
    cyc(T);
    check("rstack/ack_driven", 16'(bus.I2C_SDA_T), 16'd0);
    rst_n = 1'b0;
    #1;
    check("rstack/async_release", 16'(bus.I2C_SDA_T), 16'd1);
    cyc(2);
    rst_n = 1'b1;
    scl_m = 1'b1;
    cyc(T);
    scl_m = 1'b0;
    i2c_stop;
    model_reset();
    fab(8'h41, "rstack/fab41");
    fab(8'hFE, "rstack/fabFE");
    fab(8'h20, "rstack/fab20");
    wq = {8'h77};
    do_write(8'h33, "rstack_wr");
    fab(8'h33, "rstack_wr/fab33");
    for (int k = 0; k < 12; k++) begin
      op = int'($urandom_range(0, 2));
      if (op == 0) begin
        wq.delete();
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) wq.push_back(8'($urandom));
        do_write(8'(8'hFC + 8'($urandom_range(0, 5))), "rnd_wr");
      end else if (op == 1) begin
        do_read(1'b1, 8'(8'hFC + 8'($urandom_range(0, 5))), int'($urandom_range(1, 3)), "rnd_rd_sub");
      end else begin
        do_read(1'b0, 8'h00, int'($urandom_range(1, 3)), "rnd_rd_cont");
      end
      fab(8'(8'hFC + 8'($urandom_range(0, 5))), "rnd_fab");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
